tuner_search_seq: RTL
=====================

# tuner_search_seq

Sequencer for one ring tuner. It latches a host search command and drives the `tuner_search_phy` trigger/peaks handshake, retrying on empty results. From the returned peak list it selects one target code and hands it to the downstream lock stage over a valid/ready handshake. It sits between the host/CSR layer and the search PHY, above `tuner_ctrl_arb_phy`.

## Interface
Parameters:
- DAC_WIDTH, 8, ring tune code width
- ADC_WIDTH, 8, detected power width
- NUM_TARGET, 4, max peaks per search
- MAX_RETRY, 3, extra search attempts after an empty result
- TIMEOUT_CYCLES, 4096, peaks-wait watchdog limit (see Configuration)

Ports:
- Clock and reset. One clock; reset is asynchronous and active-low.
  - i_clk  in  1  clock
  - i_rst_n  in  1  async active-low reset
- Host command:
  - i_cmd_start  in  1  start request; sampled only in IDLE
  - i_cmd_abort  in  1  return to IDLE from any state
  - i_cmd_clear  in  1  leave ERR
  - i_cfg_start, i_cfg_end, i_cfg_stride  in  DAC_WIDTH each  search window
  - i_cfg_sel_mode  in  1  0 = max-power peak, 1 = peak by index
  - i_cfg_sel_idx  in  $clog2(NUM_TARGET)  peak index for mode 1
- Search PHY:
  - o_search_start, o_search_end, o_search_stride  out  DAC_WIDTH each  latched window
  - o_search_trig_val  out  1  trigger valid
  - i_search_trig_rdy  in  1  trigger ready
  - i_search_peaks_val  in  1  peak list valid
  - o_search_peaks_rdy  out  1  peak list ready
  - i_ring_tune_peaks  in  NUM_TARGET x DAC_WIDTH  peak tune codes
  - i_pwr_peaks  in  NUM_TARGET x ADC_WIDTH  peak powers
  - i_peaks_cnt  in  $clog2(NUM_TARGET)+1  valid entries, 0..NUM_TARGET
- Lock stage:
  - o_lock_val  out  1  target valid
  - i_lock_rdy  in  1  target ready
  - o_lock_tune  out  DAC_WIDTH  selected code
  - o_lock_pwr  out  ADC_WIDTH  selected power
- Status and monitor:
  - o_busy  out  1  high whenever not in IDLE
  - o_done  out  1  one-cycle pulse on success
  - o_err  out  1  held high in ERR
  - o_err_code  out  2  1 = no peaks, 2 = bad index, 3 = timeout
  - o_retry_cnt  out  $clog2(MAX_RETRY+1)  retries used
  - o_mon_state  out  3  current state encoding

## Operation
- State encodings: IDLE=0, TRIG=1, WAIT=2, SELECT=3, LOCK=4, DONE=5, ERR=6.
- IDLE:
  - i_cmd_start=1 latches all i_cfg_*, clears retry_cnt and o_err_code, then goes to TRIG.
  - i_cmd_start is ignored in every other state.
- TRIG: o_search_trig_val=1. On val&&rdy, go to WAIT.
- WAIT: o_search_peaks_rdy=1. On val&&rdy, capture peaks, powers and count into registers, then go to SELECT.
- SELECT: single cycle, combinational scan of the captured registers.
  - cnt==0: if retry_cnt<MAX_RETRY, increment retry_cnt and go to TRIG with the same window. Otherwise go to ERR with code 1.
  - Mode 1 with sel_idx>=cnt: go to ERR with code 2.
  - Mode 0: pick the highest pwr among entries 0..cnt-1. On equal power, the lowest index wins.
  - On success, register o_lock_tune/o_lock_pwr and go to LOCK.
- LOCK: o_lock_val=1 with stable data. On val&&rdy, go to DONE.
- DONE: o_done=1 for one cycle, then IDLE.
- ERR:
  - o_err=1 and o_err_code are held.
  - i_cmd_clear goes to IDLE and clears o_err.
  - o_err_code keeps its value until the next accepted start.
- i_cmd_abort has priority over every other transition. Next state is IDLE and all valids and readies drop the following cycle. Dropping an un-handshaken valid on abort is permitted.
- Simultaneous i_cmd_abort and i_cmd_clear in ERR: go to IDLE.

## Timing
- Reset: every output is 0, state is IDLE, all internal registers are 0.
- i_cmd_start at cycle 0 gives o_search_trig_val=1 and o_busy=1 at cycle 1.
- Peaks handshake at cycle k gives SELECT at k+1 and o_lock_val at k+2.
- Empty result at k gives o_search_trig_val again at k+2.
- Lock handshake at m gives o_done at m+1 and o_busy=0 at m+2.
- All outputs are registered or decoded from the state register only. There is no combinational path from input to output.
- Reset asserted mid-operation returns to IDLE immediately and clears all outputs.

## Configuration
- Macro: TUNER_SEARCH_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT and reloads on entry to WAIT.
  - If TIMEOUT_CYCLES cycles pass without a peaks handshake, treat it as cnt==0. Retry while retries remain; otherwise go to ERR with code 3.
- Undefined: WAIT waits indefinitely, no counter exists, and code 3 is never produced.

## Test plan
- Mode 0, cnt=3, pwr={40,90,90,xx}, tune={10,50,70,xx} -> o_lock_tune=50, o_lock_pwr=90, o_done pulses one cycle after the lock handshake.
- cnt=0 returned 4 times with MAX_RETRY=3 -> three re-triggers, o_retry_cnt=3, then ERR with code 1. i_cmd_clear -> IDLE.
- Mode 1, sel_idx=2, cnt=2 -> ERR code 2, no o_lock_val. Mode 1, sel_idx=1, cnt=2 -> o_lock_tune = entry 1.
- i_lock_rdy held low 20 cycles -> o_lock_val and o_lock_tune stay stable. i_cmd_abort -> IDLE next cycle, o_lock_val=0.
- TUNER_SEARCH_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, peaks never valid -> four triggers spaced by the timeout, then ERR code 3.
- i_rst_n pulsed low during WAIT, and i_cmd_start pulsed in LOCK -> reset clears all outputs; start in LOCK is ignored.

Source files
------------

// File: rtl/tuner_search_seq_if.sv
// Search-PHY and lock-stage handshake bundle for tuner_search_seq.
// master = sequencer side, slave = PHY / lock-stage side.
interface tuner_search_seq_if #(
  parameter int DAC_WIDTH  = 8,
  parameter int ADC_WIDTH  = 8,
  parameter int NUM_TARGET = 4
);
  logic [DAC_WIDTH-1:0]                  o_search_start;
  logic [DAC_WIDTH-1:0]                  o_search_end;
  logic [DAC_WIDTH-1:0]                  o_search_stride;
  logic                                  o_search_trig_val;
  logic                                  i_search_trig_rdy;
  logic                                  i_search_peaks_val;
  logic                                  o_search_peaks_rdy;
  logic [NUM_TARGET-1:0][DAC_WIDTH-1:0]  i_ring_tune_peaks;
  logic [NUM_TARGET-1:0][ADC_WIDTH-1:0]  i_pwr_peaks;
  logic [$clog2(NUM_TARGET):0]           i_peaks_cnt;
  logic                                  o_lock_val;
  logic                                  i_lock_rdy;
  logic [DAC_WIDTH-1:0]                  o_lock_tune;
  logic [ADC_WIDTH-1:0]                  o_lock_pwr;

  modport master (
    output o_search_start, o_search_end, o_search_stride, o_search_trig_val,
    output o_search_peaks_rdy, o_lock_val, o_lock_tune, o_lock_pwr,
    input  i_search_trig_rdy, i_search_peaks_val, i_ring_tune_peaks, i_pwr_peaks,
    input  i_peaks_cnt, i_lock_rdy
  );

  modport slave (
    input  o_search_start, o_search_end, o_search_stride, o_search_trig_val,
    input  o_search_peaks_rdy, o_lock_val, o_lock_tune, o_lock_pwr,
    output i_search_trig_rdy, i_search_peaks_val, i_ring_tune_peaks, i_pwr_peaks,
    output i_peaks_cnt, i_lock_rdy
  );
endinterface

// File: rtl/tuner_search_seq.sv
// Ring-tuner search sequencer: trigger PHY search, retry on empty lists, select a peak, hand it to lock.
// Optional peaks-wait watchdog enabled by defining TUNER_SEARCH_SEQ_TIMEOUT_EN.
module tuner_search_seq #(
  parameter int DAC_WIDTH      = 8,
  parameter int ADC_WIDTH      = 8,
  parameter int NUM_TARGET     = 4,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_cmd_start,
  input  logic                            i_cmd_abort,
  input  logic                            i_cmd_clear,
  input  logic [DAC_WIDTH-1:0]            i_cfg_start,
  input  logic [DAC_WIDTH-1:0]            i_cfg_end,
  input  logic [DAC_WIDTH-1:0]            i_cfg_stride,
  input  logic                            i_cfg_sel_mode,
  input  logic [$clog2(NUM_TARGET)-1:0]   i_cfg_sel_idx,
  tuner_search_seq_if.master              bus,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_err,
  output logic [1:0]                      o_err_code,
  output logic [$clog2(MAX_RETRY+1)-1:0]  o_retry_cnt,
  output logic [2:0]                      o_mon_state
);
  // state  | meaning
  // IDLE   | waiting for a host start
  // TRIG   | search trigger offered to the PHY
  // WAIT   | waiting for the peak list
  // SELECT | one-cycle scan of the captured peaks
  // LOCK   | selected target offered to the lock stage
  // DONE   | one-cycle success pulse
  // ERR    | held until host clear or abort
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_TRIG = 3'd1, S_WAIT = 3'd2, S_SELECT = 3'd3,
    S_LOCK = 3'd4, S_DONE = 3'd5, S_ERR = 3'd6
  } state_t;

  localparam int IDX_W   = $clog2(NUM_TARGET);
  localparam int CNT_W   = IDX_W + 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  state_t state_q, state_d;

  logic [DAC_WIDTH-1:0]                 win_start_q, win_end_q, win_stride_q;
  logic                                 mode_q;
  logic [IDX_W-1:0]                     idx_q;
  logic [NUM_TARGET-1:0][DAC_WIDTH-1:0] tune_q;
  logic [NUM_TARGET-1:0][ADC_WIDTH-1:0] pwr_q;
  logic [CNT_W-1:0]                     cnt_q;
  logic [RETRY_W-1:0]                   retry_q;
  logic [1:0]                           err_code_q;
  logic [DAC_WIDTH-1:0]                 lock_tune_q;
  logic [ADC_WIDTH-1:0]                 lock_pwr_q;

  logic                                 retry_left, idx_bad, to_expire;
  logic [IDX_W-1:0]                     best_idx, sel_idx;
  logic [ADC_WIDTH-1:0]                 best_pwr;

  assign retry_left = (retry_q < RETRY_W'(MAX_RETRY));
  assign idx_bad    = mode_q && (CNT_W'(idx_q) >= cnt_q);

`ifdef TUNER_SEARCH_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;

  // Reloaded while triggering so each WAIT visit gets the full window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                 to_cnt_q <= '0;
    else if (state_q == S_TRIG)                   to_cnt_q <= TO_W'(TIMEOUT_CYCLES - 1);
    else if (state_q == S_WAIT && to_cnt_q != '0) to_cnt_q <= to_cnt_q - 1'b1;
  end

  assign to_expire = (state_q == S_WAIT) && !bus.i_search_peaks_val && (to_cnt_q == '0);
`else
  assign to_expire = 1'b0;
`endif

  // Strict compare keeps the lowest index on equal power.
  always_comb begin
    best_idx = '0;
    best_pwr = pwr_q[0];
    for (int i = 1; i < NUM_TARGET; i++) begin
      if (CNT_W'(i) < cnt_q && pwr_q[i] > best_pwr) begin
        best_idx = IDX_W'(i);
        best_pwr = pwr_q[i];
      end
    end
    sel_idx = mode_q ? idx_q : best_idx;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_cmd_abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (i_cmd_start) state_d = S_TRIG;
        S_TRIG:   if (bus.i_search_trig_rdy) state_d = S_WAIT;
        S_WAIT: begin
          if (bus.i_search_peaks_val) state_d = S_SELECT;
          else if (to_expire)         state_d = retry_left ? S_TRIG : S_ERR;
        end
        S_SELECT: begin
          if (cnt_q == '0)  state_d = retry_left ? S_TRIG : S_ERR;
          else if (idx_bad) state_d = S_ERR;
          else              state_d = S_LOCK;
        end
        S_LOCK:   if (bus.i_lock_rdy) state_d = S_DONE;
        S_DONE:   state_d = S_IDLE;
        S_ERR:    if (i_cmd_clear) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      win_start_q  <= '0;
      win_end_q    <= '0;
      win_stride_q <= '0;
      mode_q       <= 1'b0;
      idx_q        <= '0;
      tune_q       <= '0;
      pwr_q        <= '0;
      cnt_q        <= '0;
      retry_q      <= '0;
      err_code_q   <= 2'd0;
      lock_tune_q  <= '0;
      lock_pwr_q   <= '0;
    end else if (!i_cmd_abort) begin
      case (state_q)
        S_IDLE: if (i_cmd_start) begin
          win_start_q  <= i_cfg_start;
          win_end_q    <= i_cfg_end;
          win_stride_q <= i_cfg_stride;
          mode_q       <= i_cfg_sel_mode;
          idx_q        <= i_cfg_sel_idx;
          retry_q      <= '0;
          err_code_q   <= 2'd0;
        end
        S_WAIT: begin
          if (bus.i_search_peaks_val) begin
            tune_q <= bus.i_ring_tune_peaks;
            pwr_q  <= bus.i_pwr_peaks;
            cnt_q  <= bus.i_peaks_cnt;
          end else if (to_expire) begin
            if (retry_left) retry_q    <= retry_q + 1'b1;
            else            err_code_q <= 2'd3;
          end
        end
        S_SELECT: begin
          if (cnt_q == '0) begin
            if (retry_left) retry_q    <= retry_q + 1'b1;
            else            err_code_q <= 2'd1;
          end else if (idx_bad) begin
            err_code_q <= 2'd2;
          end else begin
            lock_tune_q <= tune_q[sel_idx];
            lock_pwr_q  <= pwr_q[sel_idx];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_search_start     = win_start_q;
  assign bus.o_search_end       = win_end_q;
  assign bus.o_search_stride    = win_stride_q;
  assign bus.o_search_trig_val  = (state_q == S_TRIG);
  assign bus.o_search_peaks_rdy = (state_q == S_WAIT);
  assign bus.o_lock_val         = (state_q == S_LOCK);
  assign bus.o_lock_tune        = lock_tune_q;
  assign bus.o_lock_pwr         = lock_pwr_q;
  assign o_busy                 = (state_q != S_IDLE);
  assign o_done                 = (state_q == S_DONE);
  assign o_err                  = (state_q == S_ERR);
  assign o_err_code             = err_code_q;
  assign o_retry_cnt            = retry_q;
  assign o_mon_state            = state_q;
endmodule
